// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU execution datapath.
//   - Default operand width.
//   - shift_select encodings (SH_*), carry_select encodings (CY_*).
//   - Named 4-bit logic_op truth tables (LOP_*). Bit index {rhs, lhs} selects
//     the output, so e.g. LOP_AND = 4'b1000 is 1 only for rhs=1, lhs=1.
//   - resolve_cin(): maps a carry_select code and the stored carry to the
//     adder carry-in.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 8;

  // shift_select encodings
  localparam logic [1:0] SH_PASS  = 2'b00;  // lhs unchanged
  localparam logic [1:0] SH_LEFT  = 2'b01;  // lhs << 1, zero fill
  localparam logic [1:0] SH_RIGHT = 2'b10;  // lhs >> 1, logical
  localparam logic [1:0] SH_ZERO  = 2'b11;  // constant zero

  // carry_select encodings
  localparam logic [1:0] CY_ZERO     = 2'b00;
  localparam logic [1:0] CY_FLAG     = 2'b01;  // stored carry flag
  localparam logic [1:0] CY_ONE      = 2'b10;
  localparam logic [1:0] CY_ZERO_ALT = 2'b11;  // reserved, behaves as zero

  // logic_op truth tables
  localparam logic [3:0] LOP_ZERO = 4'b0000;
  localparam logic [3:0] LOP_RHS  = 4'b1100;
  localparam logic [3:0] LOP_NRHS = 4'b0011;
  localparam logic [3:0] LOP_AND  = 4'b1000;
  localparam logic [3:0] LOP_OR   = 4'b1110;
  localparam logic [3:0] LOP_XOR  = 4'b0110;
  localparam logic [3:0] LOP_ONES = 4'b1111;

  // Adder carry-in for a given carry_select code.
  function automatic logic resolve_cin(input logic [1:0] carry_sel,
                                       input logic       stored_c);
    logic cin;
    cin = 1'b0;
    case (carry_sel)
      CY_ZERO:     cin = 1'b0;
      CY_FLAG:     cin = stored_c;
      CY_ONE:      cin = 1'b1;
      CY_ZERO_ALT: cin = 1'b0;
      default:     cin = 1'b0;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// -----------------------------------------------------------------------------
// alu_logic_unit
// Per-bit 4:1 truth-table mux: lu_o[i] = logic_op_i[{rhs_i[i], lhs_i[i]}].
// Purely combinational.
// Ports:
//   logic_op_i  [3:0]        truth table
//   lhs_i       [WIDTH-1:0]  left operand  (index bit 0)
//   rhs_i       [WIDTH-1:0]  right operand (index bit 1)
//   lu_o        [WIDTH-1:0]  logic unit output
// -----------------------------------------------------------------------------
module alu_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       logic_op_i,
  input  logic [WIDTH-1:0] lhs_i,
  input  logic [WIDTH-1:0] rhs_i,
  output logic [WIDTH-1:0] lu_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] sel;
    assign sel     = {rhs_i[i], lhs_i[i]};
    assign lu_o[i] = logic_op_i[sel];
  end

endmodule

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
// Two-stage ALU execution datapath. Stage 1 registers the shifter output, the
// logic-unit output and the control selects on an accepted strobe; stage 2
// adds them with a carry-in resolved against the stored carry flag and
// registers the result and flags.
//
// Handshake: alu_en is a per-cycle accept strobe with no ready/backpressure;
// every rising edge with alu_en high accepts exactly one operation. The
// result appears two edges later, qualified by a one-cycle out_valid pulse;
// result and flags hold their value between pulses.
//
// Optional feature: define ALU_EXEC_OVERFLOW_EN to build the signed overflow
// flag; otherwise flag_v is tied to 0.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   alu_en        accept strobe
//   logic_op[3:0] logic-unit truth table
//   shift_select  00 lhs, 01 lhs<<1, 10 lhs>>1, 11 zero
//   carry_select  00 zero, 01 stored carry, 10 one, 11 zero
//   lhs, rhs      operands
//   result        registered result
//   out_valid     result/flags updated this cycle
//   flag_c/z/n/v  carry, zero, negative, signed overflow
//   dbg_s1_valid  stage-1 occupancy, for observation only
// -----------------------------------------------------------------------------
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_en,
  input  logic [3:0]       logic_op,
  input  logic [1:0]       shift_select,
  input  logic [1:0]       carry_select,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             dbg_s1_valid
);

  // ---------------------------------------------------------------------------
  // Stage 1: shifter + logic unit
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sh_d;
  logic             sout_d;
  logic [WIDTH-1:0] lu_d;

  always_comb begin
    sh_d   = '0;
    sout_d = 1'b0;
    case (shift_select)
      SH_PASS: begin
        sh_d = lhs;
      end
      SH_LEFT: begin
        sh_d   = {lhs[WIDTH-2:0], 1'b0};
        sout_d = lhs[WIDTH-1];
      end
      SH_RIGHT: begin
        sh_d   = {1'b0, lhs[WIDTH-1:1]};
        sout_d = lhs[0];
      end
      default: begin
        sh_d = '0;
      end
    endcase
  end

  alu_logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .logic_op_i (logic_op),
    .lhs_i      (lhs),
    .rhs_i      (rhs),
    .lu_o       (lu_d)
  );

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] lu_q;
  logic [1:0]       csel_q;
  logic [1:0]       ssel_q;
  logic             sout_q;
  logic             s1_valid_q;

  // Data registers load only on accept so an idle pipeline keeps its last
  // operands; s1_valid_q follows alu_en every cycle so the pipe drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      lu_q       <= '0;
      csel_q     <= 2'b00;
      ssel_q     <= 2'b00;
      sout_q     <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= alu_en;
      if (alu_en) begin
        sh_q   <= sh_d;
        lu_q   <= lu_d;
        csel_q <= carry_select;
        ssel_q <= shift_select;
        sout_q <= sout_d;
      end
    end
  end

  assign dbg_s1_valid = s1_valid_q;

  // ---------------------------------------------------------------------------
  // Stage 2: adder and flag generation
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic             flag_c_q;
  logic             flag_z_q;
  logic             flag_n_q;

  logic             cin;
  logic [WIDTH:0]   sum;
  logic             is_shift;
  logic             c_d;

  // cin reads the live carry register, so an op entering stage 2 sees the
  // carry written by the op one edge ahead of it: addc/subb chains run
  // back-to-back without bubbles.
  always_comb begin
    cin      = resolve_cin(csel_q, flag_c_q);
    sum      = {1'b0, sh_q} + {1'b0, lu_q} + {{WIDTH{1'b0}}, cin};
    is_shift = (ssel_q == SH_LEFT) || (ssel_q == SH_RIGHT);
    c_d      = is_shift ? sout_q : sum[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= sum[WIDTH-1:0];
        flag_c_q <= c_d;
        flag_z_q <= (sum[WIDTH-1:0] == '0);
        flag_n_q <= sum[WIDTH-1];
      end
    end
  end

`ifdef ALU_EXEC_OVERFLOW_EN
  // Signed overflow of sh + lu: operands agree in sign, sum disagrees.
  // Shift operations are not arithmetic and clear the flag.
  logic v_d;
  logic flag_v_q;

  always_comb begin
    v_d = 1'b0;
    if (!is_shift) begin
      v_d = (sh_q[WIDTH-1] == lu_q[WIDTH-1]) && (sum[WIDTH-1] != sh_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_v_q <= 1'b0;
    end else if (s1_valid_q) begin
      flag_v_q <= v_d;
    end
  end

  assign flag_v = flag_v_q;
`else
  assign flag_v = 1'b0;
`endif

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;

endmodule
